// File: rtl/tx.sv
// tx -- UART-style serial transmitter.
//
// Frames an 8-bit word as: start bit (0), 7 or 8 data bits LSB first,
// optional even/odd parity bit, then 1 or 2 stop bits (1). The line idles
// high. The frame format is latched together with the data word when a
// frame starts, so the control inputs may change freely during a frame.
//
// Request handshake: start is an active-low, level-sensitive request. It is
// sampled only in IDLE and on the final clock of the last stop bit. On such
// an edge, start=0 latches din/par/snum/dnum and drives the start bit on that
// same edge. No acknowledge is returned, so the source must hold its word
// stable until that edge. Changes to start at any other time are ignored.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per serial bit (>= 1)
// Ports:
//   clk    system clock, rising edge
//   rst    asynchronous active-low reset
//   dout   registered serial line, idles 1
//   par    parity mode: 00 even, 01 odd, 1x none
//   din    parallel data word
//   start  active-low transmit request (level)
//   snum   stop bits: 0 = two, 1 = one
//   dnum   data length: 0 = 8 bits, 1 = 7 bits (din[6:0])
//
// The FSM state is held in the internal signal 'state' (type state_t).
module tx #(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic       clk,
  input  logic       rst,
  output logic       dout,
  input  logic [1:0] par,
  input  logic [7:0] din,
  input  logic       start,
  input  logic       snum,
  input  logic       dnum
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t        state;
  logic [BW-1:0] baud_cnt;
  logic [2:0]    bit_cnt;   // data bit index in DATA, stop bit index in STOP
  logic [7:0]    shreg;     // captured word, shifted right as bits go out
  logic [1:0]    par_q;
  logic          snum_q;
  logic          dnum_q;
  logic          par_acc;   // running XOR of data bits already driven

  logic bit_end;
  logic stop_last;
  logic accept;

  assign bit_end   = (baud_cnt == BAUD_LAST);
  // The final stop bit is the only one with snum=1, or the second with snum=0.
  assign stop_last = snum_q | bit_cnt[0];
  // A new frame may begin from IDLE or directly at the end of the last stop
  // bit, which gives back-to-back frames with no idle gap.
  assign accept    = ((state == IDLE) || ((state == STOP) && bit_end && stop_last))
                     && !start;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      dout     <= 1'b1;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      par_q    <= '0;
      snum_q   <= 1'b0;
      dnum_q   <= 1'b0;
      par_acc  <= 1'b0;
    end else if (accept) begin
      state    <= START;
      dout     <= 1'b0;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= din;
      par_q    <= par;
      snum_q   <= snum;
      dnum_q   <= dnum;
      par_acc  <= 1'b0;
    end else if (state == IDLE) begin
      dout     <= 1'b1;
      baud_cnt <= '0;
    end else if (!bit_end) begin
      baud_cnt <= baud_cnt + 1'b1;
    end else begin
      baud_cnt <= '0;
      case (state)
        START: begin
          state   <= DATA;
          dout    <= shreg[0];
          par_acc <= par_acc ^ shreg[0];
          shreg   <= {1'b0, shreg[7:1]};
          bit_cnt <= '0;
        end
        DATA: begin
          if (bit_cnt == (dnum_q ? 3'd6 : 3'd7)) begin
            bit_cnt <= '0;
            if (!par_q[1]) begin
              // par_acc already covers every transmitted data bit.
              state <= PARITY;
              dout  <= par_acc ^ par_q[0];
            end else begin
              state <= STOP;
              dout  <= 1'b1;
            end
          end else begin
            bit_cnt <= bit_cnt + 3'd1;
            dout    <= shreg[0];
            par_acc <= par_acc ^ shreg[0];
            shreg   <= {1'b0, shreg[7:1]};
          end
        end
        PARITY: begin
          state   <= STOP;
          dout    <= 1'b1;
          bit_cnt <= '0;
        end
        STOP: begin
          dout <= 1'b1;
          if (stop_last) begin
            state   <= IDLE;
            bit_cnt <= '0;
          end else begin
            bit_cnt <= 3'd1;
          end
        end
        default: begin
          state <= IDLE;
          dout  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tx.sv
// Directed bench for tx with CLKS_PER_BIT=1. Every expected dout value is a
// hand-computed constant written in time order (leftmost bit first).
module tb_tx;

  logic       clk;
  logic       rst;
  logic       dout;
  logic [1:0] par;
  logic [7:0] din;
  logic       start;
  logic       snum;
  logic       dnum;

  int tests_run;
  int tests_failed;

  tx #(.CLKS_PER_BIT(1)) dut (
    .clk  (clk),
    .rst  (rst),
    .dout (dout),
    .par  (par),
    .din  (din),
    .start(start),
    .snum (snum),
    .dnum (dnum)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_bit(input string tag, input int idx, input logic exp);
    tests_run++;
    assert (dout === exp) else begin
      tests_failed++;
      $error("FAIL %s[%0d]: dout=%b expected %b", tag, idx, dout, exp);
    end
  endtask

  // Clocks n bits and checks each against pat, read MSB (earliest) first.
  task automatic run_frame(input string tag, input logic [15:0] pat, input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      check_bit(tag, i, pat[n-1-i]);
    end
  endtask

  task automatic set_fmt(input logic [7:0] d, input logic [1:0] p,
                         input logic s, input logic dn);
    din  = d;
    par  = p;
    snum = s;
    dnum = dn;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst   = 1'b1;
    start = 1'b1;
    set_fmt(8'h00, 2'b00, 1'b0, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    check_bit("reset_dout", 0, 1'b1);
    tick();
    tick();
    check_bit("reset_hold", 0, 1'b1);
    #2;
    rst = 1'b1;

    // Idle with no request: line stays high.
    run_frame("idle", 16'h0007, 3);

    // Even parity, two stop bits, start held low for back-to-back frames.
    set_fmt(8'b1010_1011, 2'b00, 1'b0, 1'b0);
    start = 1'b0;
    run_frame("even_2stop", 16'(12'b0110_1010_1111), 12);

    // Next frame begins immediately: one stop bit.
    set_fmt(8'b1010_1011, 2'b00, 1'b1, 1'b0);
    run_frame("even_1stop", 16'(11'b0110_1010_111), 11);

    // Odd parity on 0x0F: four ones, so parity bit 1.
    set_fmt(8'h0F, 2'b01, 1'b1, 1'b0);
    run_frame("odd_par", 16'(11'b0111_1000_011), 11);

    // No parity: stop bit directly after din[7]=0.
    set_fmt(8'h0F, 2'b10, 1'b1, 1'b0);
    run_frame("no_par", 16'(10'b0111_1000_01), 10);

    // 7-bit data on 0xFF: seven ones, even parity 1, din[7] not sent.
    set_fmt(8'hFF, 2'b00, 1'b1, 1'b1);
    run_frame("data7", 16'(10'b0111_1111_11), 10);

    // Request withdrawn: line returns to idle after the stop bit.
    start = 1'b1;
    run_frame("idle_after", 16'h0007, 3);

    // Capture: change every input right after the start bit.
    set_fmt(8'hA5, 2'b10, 1'b1, 1'b0);
    start = 1'b0;
    tick();
    check_bit("capture_start", 0, 1'b0);
    set_fmt(8'h00, 2'b00, 1'b0, 1'b1);
    start = 1'b1;
    run_frame("capture", 16'(9'b1010_0101_1), 9);
    run_frame("capture_idle", 16'h0003, 2);

    // Asynchronous reset at data bit 4 (line low there since din=0).
    set_fmt(8'h00, 2'b00, 1'b1, 1'b0);
    start = 1'b0;
    run_frame("pre_reset", 16'h0000, 6);
    #3;
    rst = 1'b0;
    #1;
    check_bit("async_reset", 0, 1'b1);
    tick();
    check_bit("reset_low_edge", 0, 1'b1);
    set_fmt(8'h01, 2'b00, 1'b1, 1'b0);
    rst = 1'b1;
    run_frame("after_reset", 16'(11'b0100_0000_011), 11);
    start = 1'b1;
    run_frame("final_idle", 16'h0003, 2);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
